frame_scheduler: RTL and testbench

Sequencing controller for the LED display frame path. It converts the 2-bit speed switch into a tick period and generates the frame-advance tick (`fc_clk`). It owns the frame number with wrap, single-step and direction control, and presents each new frame to the display driver through a req/ack handshake with overrun accounting. It replaces the loose switch-decoder, tick-divider and frame-counter chain with a single block that governs when frames change.

---
 rtl/display_pkg.sv | 30 +++
 rtl/tick_divider.sv | 39 +++
 rtl/frame_scheduler.sv | 111 +++++++++++
 tb/tb_frame_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared encodings, state type and helpers for the LED frame path
package display_pkg;

    localparam int FM_W = 5;
    localparam int TM_W = 27;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next frame number in the requested direction, wrapping at 0 and last
    function automatic logic [FM_W-1:0] fm_step(input logic [FM_W-1:0] fm,
                                                input logic            down,
                                                input logic [FM_W-1:0] last);
        logic [FM_W-1:0] nxt;
        if (down) begin
            nxt = (fm == '0) ? last : fm - FM_W'(1);
        end else begin
            nxt = (fm == last) ? '0 : fm + FM_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - programmable tick divider with period reload at tick boundaries
module tick_divider
    import display_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [TM_W-1:0] period_in,
    output logic            tick
);

    logic [TM_W-1:0] cnt;
    logic [TM_W-1:0] period;
    logic            at_end;

    assign at_end = (cnt == period - TM_W'(1));
    assign tick   = en && at_end;

    // Count while enabled; clr holds cnt at 0 and keeps the shadow period tracking
    // the switch so the first run interval uses the speed selected at entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= '1;
        end else if (clr) begin
            cnt    <= '0;
            period <= period_in;
        end else if (en) begin
            if (at_end) begin
                cnt    <= '0;
                period <= period_in;
            end else begin
                cnt <= cnt + TM_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - speed-controlled frame sequencer with req/ack handoff and overrun count
module frame_scheduler
    import display_pkg::*;
#(
    parameter int FRAMES      = 32,
    parameter int PERIOD_SLOW = 50000000,
    parameter int PERIOD_MED  = 20000000,
    parameter int PERIOD_FAST = 2000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      sw_state,
    input  logic            step,
    input  logic            dir,
    input  logic            frame_ack,
    output logic            fc_clk,
    output logic [FM_W-1:0] fm_no,
    output logic            frame_req,
    output logic            running,
    output logic [7:0]      overrun_cnt
);

    localparam logic [FM_W-1:0] FM_LAST = FM_W'(FRAMES - 1);

    logic [1:0]      sw_meta;
    logic [1:0]      sw_s;
    state_t          state_q;
    state_t          state_d;
    logic            in_stop;
    logic [TM_W-1:0] period_sel;
    logic            tick;
    logic            adv;

    // Two-flop synchronizer for the asynchronous speed switch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta <= MODE_STOP;
            sw_s    <= MODE_STOP;
        end else begin
            sw_meta <= sw_state;
            sw_s    <= sw_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: run whenever the synchronized switch selects a speed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (sw_s != MODE_STOP) state_d = ST_RUN;
            ST_RUN:  if (sw_s == MODE_STOP) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    assign in_stop = (state_q == ST_STOP);
    assign running = (state_q == ST_RUN);

    // Speed switch to tick period; stop position never reaches the divider in RUN
    always_comb begin
        period_sel = TM_W'(PERIOD_FAST);
        case (sw_s)
            MODE_SLOW: period_sel = TM_W'(PERIOD_SLOW);
            MODE_MED:  period_sel = TM_W'(PERIOD_MED);
            MODE_FAST: period_sel = TM_W'(PERIOD_FAST);
            default:   period_sel = TM_W'(PERIOD_FAST);
        endcase
    end

    tick_divider u_tick_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (running),
        .clr       (in_stop),
        .period_in (period_sel),
        .tick      (tick)
    );

    // A step is decided on the current state, so it still counts on the STOP->RUN edge
    assign adv = tick || (step && in_stop);

    // Frame counter, advance pulse, display handshake and overrun accounting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc_clk      <= 1'b0;
            fm_no       <= '0;
            frame_req   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            fc_clk <= adv;
            if (adv) begin
                fm_no     <= fm_step(fm_no, dir, FM_LAST);
                frame_req <= 1'b1;
                if (frame_req && !frame_ack && (overrun_cnt != 8'hFF)) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (frame_ack && frame_req) begin
                frame_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - directed vector bench for frame_scheduler
module tb_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw_state;
    logic       step;
    logic       dir;
    logic       frame_ack;
    logic       fc_clk;
    logic [4:0] fm_no;
    logic       frame_req;
    logic       running;
    logic [7:0] overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    frame_scheduler #(
        .FRAMES      (5),
        .PERIOD_SLOW (10),
        .PERIOD_MED  (6),
        .PERIOD_FAST (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_state    (sw_state),
        .step        (step),
        .dir         (dir),
        .frame_ack   (frame_ack),
        .fc_clk      (fc_clk),
        .fm_no       (fm_no),
        .frame_req   (frame_req),
        .running     (running),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic [1:0] sw;
        logic       step;
        logic       dir;
        logic       ack;
        int         ncyc;
        logic       fc;
        logic [4:0] fm;
        logic       req;
        logic       run;
        logic [7:0] ovr;
    } vec_t;

    vec_t vecs[14];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_run(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!running && n < limit);
        chk("run_entry_seen", {31'd0, running}, 32'd1);
    endtask

    task automatic wait_fc(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!fc_clk && n < limit);
        chk("fc_seen", {31'd0, fc_clk}, 32'd1);
    endtask

    initial begin
        int n;
        int ticks[$];

        rst_n = 1'b0; sw_state = 2'b11; step = 1'b0; dir = 1'b0; frame_ack = 1'b1;

        //           rst   sw     stp   dir   ack   n  fc    fm     req   run   ovr
        vecs[0]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1, 1'b0, 5'd0, 1'b0, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 3, 1'b0, 5'd0, 1'b0, 1'b1, 8'd0};
        vecs[4]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1, 1'b1, 5'd1, 1'b1, 1'b1, 8'd0};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1, 1'b0, 5'd1, 1'b0, 1'b1, 8'd0};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 3, 1'b1, 5'd2, 1'b1, 1'b1, 8'd0};
        vecs[7]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4, 1'b1, 5'd3, 1'b1, 1'b1, 8'd0};
        vecs[8]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4, 1'b1, 5'd4, 1'b1, 1'b1, 8'd0};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4, 1'b1, 5'd0, 1'b1, 1'b1, 8'd0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 3, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1, 1'b1, 5'd4, 1'b1, 1'b0, 8'd0};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 5'd4, 1'b1, 1'b0, 8'd0};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1, 1'b0, 5'd4, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst_n; sw_state = vecs[i].sw; step = vecs[i].step;
            dir = vecs[i].dir; frame_ack = vecs[i].ack;
            repeat (vecs[i].ncyc) cyc();
            chk($sformatf("v%0d fc_clk", i),      {31'd0, fc_clk},      {31'd0, vecs[i].fc});
            chk($sformatf("v%0d fm_no", i),       {27'd0, fm_no},       {27'd0, vecs[i].fm});
            chk($sformatf("v%0d frame_req", i),   {31'd0, frame_req},   {31'd0, vecs[i].req});
            chk($sformatf("v%0d running", i),     {31'd0, running},     {31'd0, vecs[i].run});
            chk($sformatf("v%0d overrun_cnt", i), {24'd0, overrun_cnt}, {24'd0, vecs[i].ovr});
        end
        step = 1'b0;

        // Speed change 01->11 at RUN cycle 3, plus a step in RUN that must be ignored
        sw_state = 2'b01; dir = 1'b0; frame_ack = 1'b1;
        do_reset();
        wait_run(8, n);
        chk("spd run_latency", n, 32'd3);
        for (int c = 1; c < 20; c++) begin
            if (c == 4) sw_state = 2'b11;
            step = (c == 6);
            cyc();
            if (fc_clk) ticks.push_back(c);
        end
        step = 1'b0;
        chk("spd tick_count", ticks.size(), 32'd3);
        if (ticks.size() >= 3) begin
            chk("spd tick1_cycle", ticks[0], 32'd10);
            chk("spd tick2_cycle", ticks[1], 32'd14);
            chk("spd tick3_cycle", ticks[2], 32'd18);
        end
        chk("spd fm_no", {27'd0, fm_no}, 32'd3);

        // Overrun accounting and saturation in FAST mode with no acks
        sw_state = 2'b11; frame_ack = 1'b0;
        do_reset();
        wait_run(8, n);
        wait_fc(10, n);
        chk("ovr first_tick_cycle", n, 32'd4);
        chk("ovr t1 frame_req", {31'd0, frame_req}, 32'd1);
        chk("ovr t1 overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
        for (int t = 2; t <= 260; t++) begin
            wait_fc(10, n);
            if (t <= 4) begin
                chk($sformatf("ovr t%0d overrun_cnt", t), {24'd0, overrun_cnt}, t - 1);
                chk($sformatf("ovr t%0d frame_req", t), {31'd0, frame_req}, 32'd1);
            end
            if (t == 255) chk("ovr t255 overrun_cnt", {24'd0, overrun_cnt}, 32'd254);
            if (t == 256) chk("ovr t256 overrun_cnt", {24'd0, overrun_cnt}, 32'd255);
            if (t == 260) chk("ovr t260 overrun_cnt", {24'd0, overrun_cnt}, 32'd255);
        end

        // Ack arriving in the same cycle as an advance, then one cycle later
        sw_state = 2'b11; frame_ack = 1'b0;
        do_reset();
        wait_run(8, n);
        wait_fc(10, n);
        chk("sim t1 frame_req", {31'd0, frame_req}, 32'd1);
        repeat (3) cyc();
        frame_ack = 1'b1;
        cyc();
        chk("sim tick fc_clk", {31'd0, fc_clk}, 32'd1);
        chk("sim tick frame_req", {31'd0, frame_req}, 32'd1);
        chk("sim tick overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
        chk("sim tick fm_no", {27'd0, fm_no}, 32'd2);
        cyc();
        chk("sim after frame_req", {31'd0, frame_req}, 32'd0);
        chk("sim after fc_clk", {31'd0, fc_clk}, 32'd0);
        frame_ack = 1'b0;

        // Reset mid-count in MED mode, then a fresh run
        sw_state = 2'b10; frame_ack = 1'b0;
        do_reset();
        wait_run(8, n);
        wait_fc(10, n);
        chk("rst first_tick_cycle", n, 32'd6);
        wait_fc(10, n);
        chk("rst t2 overrun_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("rst t2 fm_no", {27'd0, fm_no}, 32'd2);
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst fc_clk", {31'd0, fc_clk}, 32'd0);
        chk("rst fm_no", {27'd0, fm_no}, 32'd0);
        chk("rst frame_req", {31'd0, frame_req}, 32'd0);
        chk("rst running", {31'd0, running}, 32'd0);
        chk("rst overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
        rst_n = 1'b1;
        wait_run(8, n);
        chk("rst run_latency", n, 32'd3);
        wait_fc(10, n);
        chk("rst new_first_tick_cycle", n, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
